// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin sharing of one start/done multiplier among N requesters
//
// Purpose: picks one requester at a time, latches its operands, pulses
// mul_start once, waits for mul_done (or aborts after TIMEOUT wait cycles)
// and hands the product back to the winner with a one-cycle rsp_valid.
//
// Ports:
//   clk, rstn             clock, synchronous active-low reset
//   req[N]                request levels, held until own rsp_valid
//   a_flat, b_flat        packed operands, requester i at [i*W +: W]
//   gnt[N]                one-hot served index, 0 when idle
//   rsp_valid[N]          one-cycle response pulse on the served index
//   rsp_result[2W]        product (0 on timeout)
//   rsp_err               timeout flag, qualified by rsp_valid
//   busy                  high in every state except ARB
//   mul_start, mul_a/b    multiplier command
//   mul_result, mul_done  multiplier completion
module mul_share_arb #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_flat,
  input  logic [N*W-1:0]   b_flat,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     rsp_valid,
  output logic [2*W-1:0]   rsp_result,
  output logic             rsp_err,
  output logic             busy,
  output logic             mul_start,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_result,
  input  logic             mul_done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_ARB,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_HOLD
  } state_e;

  state_e           state_q;
  logic [IW-1:0]    ptr_q;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic [N-1:0]     gnt_q;
  logic [N-1:0]     rsp_valid_q;
  logic [2*W-1:0]   rsp_result_q;
  logic             rsp_err_q;
  logic             busy_q;
  logic             mul_start_q;
  logic [W-1:0]     mul_a_q;
  logic [W-1:0]     mul_b_q;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [N-1:0]     pick_oh;
  logic [IW-1:0]    scan_idx;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;

  // Round-robin scan starting just after the last winner. Walking the
  // offsets from farthest to nearest lets the nearest set request overwrite
  // the others, so the loop needs no early exit.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    scan_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      scan_idx = IW'((int'(ptr_q) + k) % N);
      if (req[scan_idx]) begin
        pick_valid        = 1'b1;
        pick_idx          = scan_idx;
        pick_oh           = '0;
        pick_oh[scan_idx] = 1'b1;
      end
    end
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_oh[i]) begin
        sel_a = a_flat[i*W +: W];
        sel_b = b_flat[i*W +: W];
      end
    end
  end

  // Counter value after this WAIT cycle; reaching TIMEOUT ends the wait.
  assign cnt_d = cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_ARB;
      ptr_q        <= IW'(N - 1);
      cnt_q        <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      mul_start_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
    end else begin
      // Pulsed outputs fall back to 0 unless a state below raises them.
      mul_start_q <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        S_ARB: begin
          if (pick_valid) begin
            gnt_q       <= pick_oh;
            mul_a_q     <= sel_a;
            mul_b_q     <= sel_b;
            ptr_q       <= pick_idx;
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          // A done in the last allowed cycle still counts as success.
          if (mul_done) begin
            rsp_result_q <= mul_result;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= gnt_q;
            state_q      <= S_RESP;
          end else if (cnt_d == 8'(TIMEOUT)) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= gnt_q;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          // Winner has dropped req by now; release everything for the next round.
          gnt_q        <= '0;
          mul_a_q      <= '0;
          mul_b_q      <= '0;
          rsp_result_q <= '0;
          rsp_err_q    <= 1'b0;
          cnt_q        <= '0;
          busy_q       <= 1'b0;
          state_q      <= S_ARB;
        end
        default: begin
          state_q <= S_ARB;
        end
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign mul_start  = mul_start_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - self-checking bench for mul_share_arb
module tb_mul_share_arb;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 32;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_flat;
  logic [N*W-1:0]   b_flat;
  logic [N-1:0]     gnt;
  logic [N-1:0]     rsp_valid;
  logic [2*W-1:0]   rsp_result;
  logic             rsp_err;
  logic             busy;
  logic             mul_start;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_result;
  logic             mul_done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n_start   = 0;
  int mul_lat   = 10;
  bit spur_done = 1'b0;
  int mdl_ptr   = N - 1;

  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];

  mul_share_arb #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .mul_done   (mul_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mul_start === 1'b1) n_start++;

  // Multiplier model: done arrives mul_lat cycles after the start cycle;
  // mul_lat == 0 means it never answers. spur_done injects a stray pulse.
  initial begin : mul_model
    int m_rem;
    bit m_run;
    logic [2*W-1:0] m_a, m_b;
    m_run = 1'b0;
    m_rem = 0;
    m_a = '0;
    m_b = '0;
    mul_done = 1'b0;
    mul_result = '0;
    forever begin
      @(posedge clk);
      #2;
      mul_done = 1'b0;
      mul_result = (2*W)'($urandom);
      if (rstn !== 1'b1) begin
        m_run = 1'b0;
      end else begin
        if (m_run) begin
          m_rem--;
          if (m_rem == 0) begin
            mul_done = 1'b1;
            mul_result = m_a * m_b;
            m_run = 1'b0;
          end
        end
        if (mul_start === 1'b1 && mul_lat > 0) begin
          m_run = 1'b1;
          m_rem = mul_lat;
          m_a = (2*W)'(mul_a);
          m_b = (2*W)'(mul_b);
        end
        if (spur_done) mul_done = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference round-robin rule: first pending index after the last winner.
  function automatic int rr_pick(input logic [N-1:0] pend, input int last);
    for (int k = 1; k <= N; k++) begin
      if (pend[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'(a) * int'(b);
    return (2*W)'(p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      a_flat[i*W +: W] = opa[i];
      b_flat[i*W +: W] = opb[i];
    end
  endtask

  task automatic wait_start(output int k);
    k = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (mul_start === 1'b1) begin
        k = c;
        return;
      end
    end
  endtask

  task automatic wait_rsp(output int k);
    k = -1;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (rsp_valid !== '0) begin
        k = c;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    mdl_ptr = N - 1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    drive_ops();
    repeat (3) tick();
    total_cnt++;
    if ({gnt, rsp_valid, rsp_result, rsp_err, busy, mul_start, mul_a, mul_b} !== '0)
      $display("FAIL reset_outputs got gnt=%b v=%b r=%h e=%b busy=%b st=%b a=%h b=%h exp all 0",
               gnt, rsp_valid, rsp_result, rsp_err, busy, mul_start, mul_a, mul_b);
    else pass_cnt++;
    rstn = 1'b1;
    mdl_ptr = N - 1;
    repeat (2) tick();
    total_cnt++;
    if ({busy, gnt} !== '0) $display("FAIL idle_after_reset got busy=%b gnt=%b exp 0", busy, gnt);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int k, s0;
    opa[0] = 4'd3;
    opb[0] = 4'd5;
    drive_ops();
    mul_lat = 10;
    s0 = n_start;
    req = 4'b0001;
    wait_start(k);
    total_cnt++;
    if (k !== 1) $display("FAIL single_grant_latency got %0d exp 1", k); else pass_cnt++;
    total_cnt++;
    if (gnt !== 4'b0001) $display("FAIL single_gnt got %b exp 0001", gnt); else pass_cnt++;
    total_cnt++;
    if ({mul_a, mul_b} !== {4'd3, 4'd5}) $display("FAIL single_operands got %h/%h exp 3/5", mul_a, mul_b); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL single_busy got %b exp 1", busy); else pass_cnt++;
    wait_rsp(k);
    total_cnt++;
    if (k !== 11) $display("FAIL single_rsp_latency got %0d exp 11", k); else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid got %b exp 0001", rsp_valid); else pass_cnt++;
    total_cnt++;
    if (rsp_result !== 8'h0F || rsp_err !== 1'b0)
      $display("FAIL single_result got %h err=%b exp 0f err=0", rsp_result, rsp_err);
    else pass_cnt++;
    total_cnt++;
    if (gnt !== 4'b0001) $display("FAIL single_gnt_resp got %b exp 0001", gnt); else pass_cnt++;
    req = '0;
    tick();
    total_cnt++;
    if (gnt !== 4'b0001 || rsp_valid !== '0)
      $display("FAIL single_hold got gnt=%b v=%b exp gnt=0001 v=0000", gnt, rsp_valid);
    else pass_cnt++;
    repeat (6) tick();
    total_cnt++;
    if (gnt !== '0 || busy !== 1'b0) $display("FAIL single_release got gnt=%b busy=%b exp 0", gnt, busy); else pass_cnt++;
    total_cnt++;
    if (n_start - s0 !== 1) $display("FAIL single_start_count got %0d exp 1", n_start - s0); else pass_cnt++;
    mdl_ptr = 0;
  endtask

  // Also covers back-to-back overhead: a pending request starts 3 cycles after RESP.
  task automatic test_contention();
    logic [N-1:0] pend, add;
    int k, w, lat, s0, served, exp_k;
    bit reraised;
    do_reset();
    opa[0] = 4'd1;  opb[0] = 4'd1;
    opa[1] = 4'd14; opb[1] = 4'd13;
    opa[2] = 4'd12; opb[2] = 4'd5;
    opa[3] = 4'd15; opb[3] = 4'd15;
    drive_ops();
    pend = 4'b1111;
    req = pend;
    reraised = 1'b0;
    served = 0;
    s0 = n_start;
    for (int s = 0; s < 24 && pend != '0; s++) begin
      w = rr_pick(pend, mdl_ptr);
      lat = $urandom_range(1, 12);
      mul_lat = lat;
      exp_k = (s == 0) ? 1 : 3;
      wait_start(k);
      total_cnt++;
      if (k !== exp_k) $display("FAIL cont_start_gap s=%0d got %0d exp %0d", s, k, exp_k); else pass_cnt++;
      total_cnt++;
      if (gnt !== onehot(w)) $display("FAIL cont_gnt s=%0d got %b exp %b", s, gnt, onehot(w)); else pass_cnt++;
      total_cnt++;
      if ({mul_a, mul_b} !== {opa[w], opb[w]})
        $display("FAIL cont_operands s=%0d got %h/%h exp %h/%h", s, mul_a, mul_b, opa[w], opb[w]);
      else pass_cnt++;
      wait_rsp(k);
      total_cnt++;
      if (k !== lat + 1) $display("FAIL cont_latency s=%0d got %0d exp %0d", s, k, lat + 1); else pass_cnt++;
      total_cnt++;
      if (rsp_valid !== onehot(w) || rsp_result !== prod(opa[w], opb[w]) || rsp_err !== 1'b0)
        $display("FAIL cont_rsp s=%0d got v=%b r=%0d e=%b exp v=%b r=%0d e=0",
                 s, rsp_valid, rsp_result, rsp_err, onehot(w), prod(opa[w], opb[w]));
      else pass_cnt++;
      served++;
      req[w] = 1'b0;
      pend[w] = 1'b0;
      mdl_ptr = w;
      if (w == 1 && !reraised) begin
        reraised = 1'b1;
        opa[0] = 4'($urandom);
        opb[0] = 4'($urandom);
        drive_ops();
        req[0] = 1'b1;
        pend[0] = 1'b1;
      end else if (s >= 4 && s < 18) begin
        add = 4'($urandom_range(0, 15)) & ~pend & ~onehot(w);
        if (pend == '0 && add == '0) add = onehot((w + 1 + $urandom_range(0, N - 2)) % N);
        for (int i = 0; i < N; i++) begin
          if (add[i]) begin
            opa[i] = 4'($urandom);
            opb[i] = 4'($urandom);
          end
        end
        drive_ops();
        req = req | add;
        pend = pend | add;
      end
    end
    repeat (3) tick();
    total_cnt++;
    if (n_start - s0 !== served) $display("FAIL cont_start_count got %0d exp %0d", n_start - s0, served); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int k, i, j;
    repeat (3) tick();
    i = $urandom_range(0, N - 1);
    opa[i] = 4'($urandom);
    opb[i] = 4'($urandom);
    drive_ops();
    mul_lat = 0;
    req = onehot(i);
    wait_start(k);
    mdl_ptr = i;
    wait_rsp(k);
    total_cnt++;
    if (k !== TO + 1) $display("FAIL timeout_latency got %0d exp %0d", k, TO + 1); else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== onehot(i) || rsp_err !== 1'b1 || rsp_result !== '0)
      $display("FAIL timeout_rsp got v=%b e=%b r=%h exp v=%b e=1 r=00", rsp_valid, rsp_err, rsp_result, onehot(i));
    else pass_cnt++;
    req = '0;
    repeat (3) tick();
    j = $urandom_range(0, N - 1);
    opa[j] = 4'($urandom);
    opb[j] = 4'($urandom);
    drive_ops();
    mul_lat = 4;
    req = onehot(j);
    wait_start(k);
    total_cnt++;
    if (gnt !== onehot(j)) $display("FAIL after_timeout_gnt got %b exp %b", gnt, onehot(j)); else pass_cnt++;
    wait_rsp(k);
    total_cnt++;
    if (k !== 5 || rsp_err !== 1'b0 || rsp_result !== prod(opa[j], opb[j]))
      $display("FAIL after_timeout_rsp got k=%0d e=%b r=%0d exp k=5 e=0 r=%0d", k, rsp_err, rsp_result, prod(opa[j], opb[j]));
    else pass_cnt++;
    req = '0;
    mdl_ptr = j;
  endtask

  task automatic test_spurious_done();
    int k, i, s0;
    repeat (3) tick();
    s0 = n_start;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick();
    total_cnt++;
    if ({busy, gnt, rsp_valid, mul_start} !== '0)
      $display("FAIL spur_arb got busy=%b gnt=%b v=%b st=%b exp 0", busy, gnt, rsp_valid, mul_start);
    else pass_cnt++;
    total_cnt++;
    if (n_start !== s0) $display("FAIL spur_arb_start got %0d exp %0d", n_start, s0); else pass_cnt++;
    i = $urandom_range(0, N - 1);
    opa[i] = 4'($urandom);
    opb[i] = 4'($urandom);
    drive_ops();
    mul_lat = 3;
    req = onehot(i);
    wait_start(k);
    wait_rsp(k);
    req = '0;
    tick();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    total_cnt++;
    if ({busy, gnt, rsp_valid} !== '0)
      $display("FAIL spur_hold got busy=%b gnt=%b v=%b exp 0", busy, gnt, rsp_valid);
    else pass_cnt++;
    repeat (2) tick();
    total_cnt++;
    if ({busy, rsp_valid, mul_start} !== '0)
      $display("FAIL spur_hold_after got busy=%b v=%b st=%b exp 0", busy, rsp_valid, mul_start);
    else pass_cnt++;
    mdl_ptr = i;
    i = $urandom_range(0, N - 1);
    opa[i] = 4'($urandom);
    opb[i] = 4'($urandom);
    drive_ops();
    mul_lat = TO;
    req = onehot(i);
    wait_start(k);
    wait_rsp(k);
    total_cnt++;
    if (k !== TO + 1 || rsp_err !== 1'b0 || rsp_result !== prod(opa[i], opb[i]))
      $display("FAIL done_at_timeout got k=%0d e=%b r=%0d exp k=%0d e=0 r=%0d",
               k, rsp_err, rsp_result, TO + 1, prod(opa[i], opb[i]));
    else pass_cnt++;
    req = '0;
    mdl_ptr = i;
  endtask

  task automatic test_reset_mid_wait();
    int k, w;
    repeat (3) tick();
    for (int i = 0; i < N; i++) begin
      opa[i] = 4'($urandom);
      opb[i] = 4'($urandom);
    end
    drive_ops();
    mul_lat = 0;
    req = 4'b1111;
    w = rr_pick(4'b1111, mdl_ptr);
    wait_start(k);
    total_cnt++;
    if (gnt !== onehot(w)) $display("FAIL midrst_first_gnt got %b exp %b", gnt, onehot(w)); else pass_cnt++;
    repeat (5) tick();
    mul_lat = 6;
    do_reset();
    total_cnt++;
    if ({gnt, rsp_valid, rsp_result, rsp_err, busy, mul_start, mul_a, mul_b} !== '0)
      $display("FAIL midrst_outputs got gnt=%b v=%b r=%h e=%b busy=%b st=%b a=%h b=%h exp all 0",
               gnt, rsp_valid, rsp_result, rsp_err, busy, mul_start, mul_a, mul_b);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (gnt !== onehot(rr_pick(4'b1111, mdl_ptr)) || mul_start !== 1'b1)
      $display("FAIL midrst_regrant got gnt=%b st=%b exp gnt=0001 st=1", gnt, mul_start);
    else pass_cnt++;
    wait_rsp(k);
    total_cnt++;
    if (k !== 7 || rsp_valid !== 4'b0001 || rsp_result !== prod(opa[0], opb[0]))
      $display("FAIL midrst_rsp got k=%0d v=%b r=%0d exp k=7 v=0001 r=%0d", k, rsp_valid, rsp_result, prod(opa[0], opb[0]));
    else pass_cnt++;
    req = '0;
    mdl_ptr = 0;
  endtask

  task automatic test_operand_stability();
    int k, i;
    logic [W-1:0] oa, ob;
    repeat (3) tick();
    i = $urandom_range(0, N - 1);
    oa = 4'($urandom);
    ob = 4'($urandom);
    opa[i] = oa;
    opb[i] = ob;
    drive_ops();
    mul_lat = 8;
    req = onehot(i);
    wait_start(k);
    opa[i] = ~oa;
    opb[i] = ~ob;
    drive_ops();
    tick();
    total_cnt++;
    if ({mul_a, mul_b} !== {oa, ob}) $display("FAIL stable_operands got %h/%h exp %h/%h", mul_a, mul_b, oa, ob); else pass_cnt++;
    wait_rsp(k);
    total_cnt++;
    if (rsp_result !== prod(oa, ob) || rsp_valid !== onehot(i))
      $display("FAIL stable_result got r=%0d v=%b exp r=%0d v=%b", rsp_result, rsp_valid, prod(oa, ob), onehot(i));
    else pass_cnt++;
    req = '0;
    mdl_ptr = i;
    repeat (3) tick();
  endtask

  initial begin
    rstn = 1'b0;
    req = '0;
    a_flat = '0;
    b_flat = '0;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_spurious_done();
    test_reset_mid_wait();
    test_operand_stability();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
